// File: rtl/zx_intrst_pkg.sv
// Shared register map and CTRL bit positions for the ZX interrupt/reset controller.
package zx_intrst_pkg;

   localparam logic [2:0] A_RAW      = 3'd0;
   localparam logic [2:0] A_PEND     = 3'd1;
   localparam logic [2:0] A_ENA      = 3'd2;
   localparam logic [2:0] A_MODE     = 3'd3;
   localparam logic [2:0] A_CTRL     = 3'd4;
   localparam logic [2:0] A_RSTLVL   = 3'd5;
   localparam logic [2:0] A_RSTPULSE = 3'd6;

   localparam int B_EINTENA = 6;
   localparam int B_INT     = 7;

endpackage

// File: rtl/zx_rst_pulse.sv
// One peripheral reset output: stored release level plus a timed auto-release pulse.
module zx_rst_pulse
   import zx_intrst_pkg::*;
#(
   parameter int RST_CYCLES = 1024,
   parameter int CW         = 11
) (
   input  logic i_fclk,
   input  logic i_rst,
   input  logic i_lvl_we,
   input  logic i_lvl_d,
   input  logic i_start,
   output logic o_lvl,
   output logic o_busy,
   output logic o_rst_n
);

   logic [CW-1:0] r_cnt;
   logic          r_lvl;
   logic          r_busy;
   logic          r_rst_n;

   always_ff @(posedge i_fclk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_lvl   <= 1'b0;
         r_busy  <= 1'b0;
         r_rst_n <= 1'b0;
      end else begin
         if (i_lvl_we) r_lvl <= i_lvl_d;
         // A restart while busy simply reloads the count.
         if (i_start) begin
            r_cnt  <= CW'(RST_CYCLES);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_busy <= 1'b0;
         end
         r_rst_n <= r_lvl & ~r_busy;
      end
   end

   assign o_lvl   = r_lvl;
   assign o_busy  = r_busy;
   assign o_rst_n = r_rst_n;

endmodule

// File: rtl/zx_intrst_ctl.sv
// Interrupt and reset controller: NCH latched interrupt channels, NRST reset outputs,
// byte register bus towards the Z80 port decoder.
module zx_intrst_ctl
   import zx_intrst_pkg::*;
#(
   parameter int         NCH        = 2,
   parameter int         NRST       = 2,
   parameter logic [7:0] POL        = 8'h01,
   parameter int         RST_CYCLES = 1024,
   parameter int         CW         = 11
) (
   input  logic            fclk,
   input  logic            rst,
   input  logic [2:0]      reg_addr,
   input  logic            reg_wr,
   input  logic            reg_rd,
   input  logic [7:0]      reg_wdata,
   output logic [7:0]      reg_rdata,
   input  logic [NCH-1:0]  irq_in,
   output logic [NRST-1:0] dev_rst_n,
   output logic            int_int,
   output logic            zint_n
);

   logic [NCH-1:0]  r_sync1;
   logic [NCH-1:0]  r_sync2;
   logic [NCH-1:0]  r_act_d;
   logic [NCH-1:0]  r_pend;
   logic [NCH-1:0]  r_ena;
   logic [NCH-1:0]  r_mode;
   logic            r_eintena;
   logic            r_int;
   logic            r_zint_n;

   logic [NCH-1:0]  w_act;
   logic [NCH-1:0]  w_set;
   logic [NCH-1:0]  w_clr;
   logic            w_wr_lvl;
   logic            w_wr_pulse;
   logic [NRST-1:0] w_lvl;
   logic [NRST-1:0] w_busy;
   logic [NRST-1:0] w_rst_n;
   logic            w_unused;

   // act is 1 when a line is at its asserted level, whatever its polarity.
   assign w_act = r_sync2 ^ ~POL[NCH-1:0];
   assign w_set = (r_mode & w_act & ~r_act_d) | (~r_mode & w_act);
   assign w_clr = (reg_wr && reg_addr == A_PEND) ? reg_wdata[NCH-1:0] : '0;

   assign w_wr_lvl   = reg_wr && (reg_addr == A_RSTLVL);
   assign w_wr_pulse = reg_wr && (reg_addr == A_RSTPULSE);

   always_ff @(posedge fclk) begin
      if (rst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_act_d   <= '0;
         r_pend    <= '0;
         r_ena     <= '0;
         r_mode    <= '0;
         r_eintena <= 1'b0;
         r_int     <= 1'b0;
         r_zint_n  <= 1'b1;
      end else begin
         r_sync1 <= irq_in;
         r_sync2 <= r_sync1;
         r_act_d <= w_act;
         // Set dominates clear, so level sources stay pending while asserted.
         r_pend  <= (r_pend & ~w_clr) | w_set;
         if (reg_wr && reg_addr == A_ENA)  r_ena     <= reg_wdata[NCH-1:0];
         if (reg_wr && reg_addr == A_MODE) r_mode    <= reg_wdata[NCH-1:0];
         if (reg_wr && reg_addr == A_CTRL) r_eintena <= reg_wdata[B_EINTENA];
         r_int    <= |(r_pend & r_ena);
         r_zint_n <= ~(r_int & r_eintena);
      end
   end

   for (genvar g = 0; g < NRST; g++) begin : g_rst
      zx_rst_pulse #(
         .RST_CYCLES(RST_CYCLES),
         .CW        (CW)
      ) u_pulse (
         .i_fclk  (fclk),
         .i_rst   (rst),
         .i_lvl_we(w_wr_lvl),
         .i_lvl_d (reg_wdata[g]),
         .i_start (w_wr_pulse & reg_wdata[g]),
         .o_lvl   (w_lvl[g]),
         .o_busy  (w_busy[g]),
         .o_rst_n (w_rst_n[g])
      );
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         A_RAW:      reg_rdata[NCH-1:0]  = w_act;
         A_PEND:     reg_rdata[NCH-1:0]  = r_pend;
         A_ENA:      reg_rdata[NCH-1:0]  = r_ena;
         A_MODE:     reg_rdata[NCH-1:0]  = r_mode;
         A_CTRL: begin
            reg_rdata[B_EINTENA] = r_eintena;
            reg_rdata[B_INT]     = r_int;
         end
         A_RSTLVL:   reg_rdata[NRST-1:0] = w_lvl;
         A_RSTPULSE: reg_rdata[NRST-1:0] = w_busy;
         default:    reg_rdata = '0;
      endcase
   end

   // Reads have no side effects, so the read strobe is not needed.
   assign w_unused = ^{reg_rd, reg_wdata};

   assign int_int   = r_int;
   assign zint_n    = r_zint_n;
   assign dev_rst_n = w_rst_n;

endmodule
